shifter_pipe: RTL and testbench
===============================

Name: shifter_pipe

Overview:
- Pipelined, parametrised successor to the combinational 16-bit shifter.
- Same 3-bit mode encoding, generalised to WIDTH bits.
- Barrel levels are split across STAGES register stages, with valid/ready handshake and backpressure.
- Sits between operand fetch and writeback in the ALU datapath, where the single-cycle 16-bit shifter no longer meets timing at wider widths.

Parameters:
- WIDTH, 16: data width; power of 2, 8..64.
- STAGES, 2: pipeline register stages, 1..log2(WIDTH); equals latency in cycles.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand this cycle.
- in  in  WIDTH  operand.
- n  in  log2(WIDTH)  shift/rotate amount.
- mode  in  3  shift_mode_e.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out  out  WIDTH  result.
- carry  out  1  last bit shifted or rotated out (flags feature).
- zero  out  1  out == 0 (flags feature).

Behaviour:
- Reset (async assert, sync-released by the clock domain): all stage valid bits 0; out, carry and zero 0; out_valid 0; in_ready 1.
- Mode encoding:
  - 000 and 100: pass.
  - 001: logical right.
  - 010: arithmetic right (sign-fill from in[WIDTH-1]).
  - 011: rotate right.
  - 101 and 110: logical left.
  - 111: rotate left.
- Amount n is unsigned, 0..WIDTH-1. n=0 returns in for every mode. No modulo beyond the port width.
- Datapath:
  - Barrel shifter of L = log2(WIDTH) levels; level k shifts by 2^k when n[k]=1.
  - Right modes are implemented as a right barrel. Left modes use the same structure on a bit-reversed operand, with the result reversed back.
  - Levels are assigned to stages as ceil(L/STAGES) per stage from LSB level upward; the last stage takes the remainder.
  - A register sits after each stage, carrying data, the remaining n bits, mode and the partial carry.
- Handshake, global-stall pipeline:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - A transfer occurs when in_valid & in_ready.
  - When stall=1, all stage registers hold and every output is stable.
  - When stall=0, each stage advances. Stage 0 valid takes (in_valid & in_ready); bubbles propagate as valid=0.
- Latency: a result appears on out exactly STAGES cycles after acceptance, with no stalls. Throughput is one result per cycle when out_ready is held high.
- Simultaneous events: an input accepted in the same cycle that the output is consumed is legal and required for full throughput.
- Reset mid-operation: all in-flight operands are discarded; none reappear after reset release.
- Outputs are held while out_valid=1 and out_ready=0 (AXI-style stability). in, n and mode are sampled only on transfer.

Optional Feature:
- Macro SHIFTER_PIPE_FLAGS_EN.
- Defined: carry and zero are computed and pipelined alongside data.
  - lsr/asr: carry = in[n-1].
  - lsl: carry = in[WIDTH-n].
  - ror: carry = out[WIDTH-1].
  - rol: carry = out[0].
  - n=0 or pass modes: carry = 0.
  - zero = (out == 0).
- Undefined: carry and zero tied to 0, and no flag registers are instantiated.

Decomposition:
- Package defs gains:
  - shift_mode_e enum, with the encodings above.
  - SHIFT_MODE_W = 3.
  - Helper functions is_left(mode) and is_rotate(mode).
- One sub-module, shifter_level: a single barrel level parametrised by WIDTH and SHIFT = 2^k. Inputs are data, enable bit, rotate flag and fill bit; outputs are shifted data and the bits shifted out. It is instantiated L times via generate.

Test Plan (WIDTH=16, STAGES=2, flags enabled):
- Reset, then in=16'h8001, n=4, mode=001 -> 2 cycles later out=16'h0800, carry=0, zero=0, out_valid=1.
- in=16'h8001, n=4, mode=010 -> out=16'hF800. Mode 011 with the same operands -> out=16'h1800, carry=0.
- in=16'h8001, n=1, mode=101 -> out=16'h0002, carry=1. Mode 111 -> out=16'h0003, carry=1.
- in=16'h0001, n=1, mode=001 -> out=16'h0000, zero=1, carry=1.
- Back-to-back stream of 8 random operands with out_ready=1 -> 8 results on 8 consecutive cycles, matching the software model.
- Stream with out_ready deasserted for 3 cycles mid-stream -> in_ready=0 during the stall, out stable, no loss or duplication. Then assert rst_n=0 mid-stream -> out_valid=0 immediately, and no stale results after release.

Source files
------------

// File: rtl/shifter_pipe_pkg.sv
// Shared definitions for shifter_pipe: shift mode encoding and mode-class helpers.
package shifter_pipe_pkg;

  localparam int SHIFT_MODE_W = 3;

  typedef enum logic [SHIFT_MODE_W-1:0] {
    SM_PASS     = 3'b000,
    SM_LSR      = 3'b001,
    SM_ASR      = 3'b010,
    SM_ROR      = 3'b011,
    SM_PASS_ALT = 3'b100,
    SM_LSL      = 3'b101,
    SM_LSL_ALT  = 3'b110,
    SM_ROL      = 3'b111
  } shift_mode_e;

  function automatic logic is_left(shift_mode_e m);
    return (m == SM_LSL) || (m == SM_LSL_ALT) || (m == SM_ROL);
  endfunction

  function automatic logic is_rotate(shift_mode_e m);
    return (m == SM_ROR) || (m == SM_ROL);
  endfunction

  function automatic logic is_pass(shift_mode_e m);
    return (m == SM_PASS) || (m == SM_PASS_ALT);
  endfunction

endpackage

// File: rtl/shifter_pipe_level.sv
// One barrel level: right shift/rotate by SHIFT when enabled.
// shout_o is the last bit this level would shift out (data_i[SHIFT-1]).
module shifter_level #(
  parameter int WIDTH = 16,
  parameter int SHIFT = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             en_i,
  input  logic             rot_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] data_o,
  output logic             shout_o
);

  logic [WIDTH-1:0] shifted;

  assign shifted = rot_i ? {data_i[SHIFT-1:0], data_i[WIDTH-1:SHIFT]}
                         : {{SHIFT{fill_i}}, data_i[WIDTH-1:SHIFT]};
  assign data_o  = en_i ? shifted : data_i;
  assign shout_o = data_i[SHIFT-1];

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter with global-stall valid/ready handshake.
// Define SHIFTER_PIPE_FLAGS_EN to compute and pipeline the carry/zero flags.
module shifter_pipe
  import shifter_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in,
  input  logic [$clog2(WIDTH)-1:0] n,
  input  logic [SHIFT_MODE_W-1:0]  mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out,
  output logic                     carry,
  output logic                     zero
);

  localparam int L   = $clog2(WIDTH);
  localparam int LPS = (L + STAGES - 1) / STAGES;

  logic              stall;
  logic [STAGES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]  data_q  [STAGES];
  logic [L-1:0]      n_q     [STAGES];
  shift_mode_e       mode_q  [STAGES];

  logic [WIDTH-1:0]  st_data [STAGES];
  logic [L-1:0]      st_n    [STAGES];
  shift_mode_e       st_mode [STAGES];
  logic [WIDTH-1:0]  st_raw  [STAGES];
  logic [WIDTH-1:0]  data_d  [STAGES];
  logic [WIDTH-1:0]  lv_in   [L];
  logic [WIDTH-1:0]  lv_out  [L];

  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] x);
    for (int i = 0; i < WIDTH; i++) rev[i] = x[WIDTH-1-i];
  endfunction

  assign stall     = valid_q[STAGES-1] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = valid_q[STAGES-1];
  assign out       = data_q[STAGES-1];

  // Left modes run through the right barrel on a bit-reversed operand.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int FIRST = s * LPS;
    localparam int LAST  = ((((s + 1) * LPS) < L) ? ((s + 1) * LPS) : L) - 1;
    if (s == 0) begin : g_head
      shift_mode_e mode_in;
      assign mode_in    = shift_mode_e'(mode);
      assign st_mode[s] = mode_in;
      assign st_n[s]    = n;
      assign st_data[s] = is_left(mode_in) ? rev(in) : in;
    end else begin : g_mid
      assign st_mode[s] = mode_q[s-1];
      assign st_n[s]    = n_q[s-1];
      assign st_data[s] = data_q[s-1];
    end
    if (FIRST >= L) begin : g_empty
      assign st_raw[s] = st_data[s];
    end else begin : g_levels
      assign st_raw[s] = lv_out[LAST];
    end
    if (s == STAGES - 1) begin : g_tail
      assign data_d[s] = is_left(st_mode[s]) ? rev(st_raw[s]) : st_raw[s];
    end else begin : g_pass
      assign data_d[s] = st_raw[s];
    end
  end

`ifdef SHIFTER_PIPE_FLAGS_EN
  logic [STAGES-1:0] carry_q, carry_d, st_c;
  logic              zero_q, zero_d;
  logic [L-1:0]      lv_cin, lv_cout;
`endif

  for (genvar k = 0; k < L; k++) begin : g_level
    localparam int S = k / LPS;
    logic en, fill, shout;
    assign en   = st_n[S][k] & ~is_pass(st_mode[S]);
    assign fill = (st_mode[S] == SM_ASR) & lv_in[k][WIDTH-1];
    if (k % LPS == 0) begin : g_first
      assign lv_in[k] = st_data[S];
    end else begin : g_chain
      assign lv_in[k] = lv_out[k-1];
    end
    shifter_level #(.WIDTH(WIDTH), .SHIFT(1 << k)) u_level (
      .data_i  (lv_in[k]),
      .en_i    (en),
      .rot_i   (is_rotate(st_mode[S])),
      .fill_i  (fill),
      .data_o  (lv_out[k]),
      .shout_o (shout)
    );
`ifdef SHIFTER_PIPE_FLAGS_EN
    if (k % LPS == 0) begin : g_cfirst
      assign lv_cin[k] = st_c[S];
    end else begin : g_cchain
      assign lv_cin[k] = lv_cout[k-1];
    end
    assign lv_cout[k] = en ? shout : lv_cin[k];
`else
    logic unused_shout;
    assign unused_shout = shout;
`endif
  end

  always_comb begin
    valid_d    = '0;
    valid_d[0] = in_valid & in_ready;
    for (int s = 1; s < STAGES; s++) valid_d[s] = valid_q[s-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= '0;
        n_q[s]    <= '0;
        mode_q[s] <= SM_PASS;
      end
    end else if (!stall) begin
      valid_q <= valid_d;
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= data_d[s];
        n_q[s]    <= st_n[s];
        mode_q[s] <= st_mode[s];
      end
    end
  end

`ifdef SHIFTER_PIPE_FLAGS_EN
  // Partial carry rides with the data; the last enabled level wins.
  for (genvar s = 0; s < STAGES; s++) begin : g_flag_stage
    localparam int FIRST = s * LPS;
    localparam int LAST  = ((((s + 1) * LPS) < L) ? ((s + 1) * LPS) : L) - 1;
    if (s == 0) begin : g_c0
      assign st_c[s] = 1'b0;
    end else begin : g_cn
      assign st_c[s] = carry_q[s-1];
    end
    if (FIRST >= L) begin : g_cempty
      assign carry_d[s] = st_c[s];
    end else begin : g_clev
      assign carry_d[s] = lv_cout[LAST];
    end
  end

  assign zero_d = (data_d[STAGES-1] == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= '0;
      zero_q  <= 1'b0;
    end else if (!stall) begin
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign carry = carry_q[STAGES-1];
  assign zero  = zero_q;
`else
  assign carry = 1'b0;
  assign zero  = 1'b0;
`endif

endmodule

// File: tb/tb_shifter_pipe.sv
// Scoreboard bench for shifter_pipe (WIDTH=16, STAGES=2).
module tb_shifter_pipe;

`ifdef SHIFTER_PIPE_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] d;
    logic        c;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] din = '0;
  logic [3:0]  sh = '0;
  logic [2:0]  md = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] dout;
  logic        carry, zero;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   run = 0;
  int   max_run = 0;

  shifter_pipe #(.WIDTH(16), .STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (din),
    .n         (sh),
    .mode      (md),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dout),
    .carry     (carry),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
    end
  endfunction

  function automatic exp_t mk(logic [15:0] d, logic c, logic z);
    exp_t r;
    r.d = d; r.c = c; r.z = z;
    return r;
  endfunction

  function automatic exp_t model(logic [15:0] a, int s, int m);
    logic [15:0] r;
    logic        c;
    r = a;
    c = 1'b0;
    if (s != 0) begin
      case (m)
        1: begin r = a >> s; c = a[s-1]; end
        2: begin r = 16'($signed(a) >>> s); c = a[s-1]; end
        3: begin r = (a >> s) | (a << (16 - s)); c = r[15]; end
        5, 6: begin r = a << s; c = a[16-s]; end
        7: begin r = (a << s) | (a >> (16 - s)); c = r[0]; end
        default: ;
      endcase
    end
    return mk(r, c, r == 16'h0);
  endfunction

  // Monitor: a result is consumed at the posedge following a negedge with valid&ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      run++;
      if (run > max_run) max_run = run;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0h expected=none", dout);
      end else begin
        e = q.pop_front();
        check("out", dout, e.d);
        check("carry", carry, FLAGS ? e.c : 1'b0);
        check("zero", zero, FLAGS ? e.z : 1'b0);
      end
    end else begin
      run = 0;
    end
  end

  task automatic send(input logic [15:0] a, input logic [3:0] s, input logic [2:0] m,
                      input exp_t ex);
    din = a; sh = s; md = m; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        q.push_back(ex);
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL send_timeout actual=in_ready_low expected=accept");
    in_valid = 1'b0;
  endtask

  task automatic idle(input int k);
    in_valid = 1'b0;
    repeat (k) @(posedge clk);
    #1;
  endtask

  int   seen;
  logic [15:0] held;
  logic        held_c;

  initial begin
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out", dout, 0);
    check("rst_carry", carry, 0);
    check("rst_zero", zero, 0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    send(16'h8001, 4'd4, 3'b001, mk(16'h0800, 1'b0, 1'b0));
    in_valid = 1'b0;
    @(negedge clk); check("lat_cyc1_valid", out_valid, 0);
    @(negedge clk); check("lat_cyc2_valid", out_valid, 1);
    idle(3);

    send(16'h8001, 4'd4,  3'b010, mk(16'hF800, 1'b0, 1'b0));
    send(16'h8001, 4'd4,  3'b011, mk(16'h1800, 1'b0, 1'b0));
    send(16'h8001, 4'd1,  3'b101, mk(16'h0002, 1'b1, 1'b0));
    send(16'h8001, 4'd1,  3'b111, mk(16'h0003, 1'b1, 1'b0));
    send(16'h0001, 4'd1,  3'b001, mk(16'h0000, 1'b1, 1'b1));
    send(16'hA5C3, 4'd0,  3'b111, mk(16'hA5C3, 1'b0, 1'b0));
    send(16'h8001, 4'd4,  3'b100, mk(16'h8001, 1'b0, 1'b0));
    send(16'h8000, 4'd15, 3'b010, mk(16'hFFFF, 1'b0, 1'b0));
    send(16'h0003, 4'd15, 3'b110, mk(16'h8000, 1'b1, 1'b0));
    send(16'h0000, 4'd7,  3'b000, mk(16'h0000, 1'b0, 1'b1));
    idle(4);

    max_run = 0;
    for (int i = 0; i < 8; i++) begin
      logic [15:0] a;
      logic [3:0]  s;
      logic [2:0]  m;
      a = 16'($urandom);
      s = 4'($urandom_range(15, 0));
      m = 3'($urandom_range(7, 0));
      send(a, s, m, model(a, int'(s), int'(m)));
    end
    idle(4);
    check("b2b_run", max_run, 8);

    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic [15:0] a;
          logic [3:0]  s;
          logic [2:0]  m;
          a = 16'h1357 + 16'(i * 16'h1111);
          s = 4'(i * 3 + 1);
          m = 3'(i + 1);
          send(a, s, m, model(a, int'(s), int'(m)));
        end
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("stall_out_valid", out_valid, 1);
        check("stall_in_ready", in_ready, 0);
        held = dout;
        held_c = carry;
        repeat (2) begin
          @(posedge clk);
          @(negedge clk);
          check("stall_out_hold", dout, held);
          check("stall_carry_hold", carry, held_c);
          check("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(5);
    check("stall_drain", q.size(), 0);

    send(16'h1234, 4'd3, 3'b001, model(16'h1234, 3, 1));
    send(16'h00F0, 4'd2, 3'b111, model(16'h00F0, 2, 7));
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out", dout, 0);
    check("midrst_in_ready", in_ready, 1);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_stale", seen, 0);
    @(posedge clk); #1;
    send(16'h00FF, 4'd4, 3'b011, mk(16'hF00F, 1'b1, 1'b0));
    in_valid = 1'b0;

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("final_drain", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
